// File: rtl/isa_issuer_pkg.sv
// Shared constants and types for the instruction issuer: opcodes, burst strides
// and the FSM state encoding.
package isa_issuer_pkg;

  localparam int unsigned OP_W     = 2;
  localparam int unsigned NBURST_W = 8;

  localparam logic [OP_W-1:0] OP_READ  = 2'b01;
  localparam logic [OP_W-1:0] OP_WRITE = 2'b10;

  // Byte strides: read bursts are 8 words, write bursts 16 words, 4 B each.
  localparam int unsigned STRIDE_READ  = 32;
  localparam int unsigned STRIDE_WRITE = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/isa_issuer_if.sv
// Host command channel plus instruction-FIFO / consumer feedback bundle.
interface isa_issuer_if
  import isa_issuer_pkg::*;
#(
  parameter int unsigned ISA  = 2,
  parameter int unsigned ADDR = 32
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ISA-1:0]        cmd_op;
  logic [ADDR-1:0]       cmd_addr;
  logic [NBURST_W-1:0]   cmd_nburst;
  logic                  ISA_FIFO_full;
  logic [ISA+ADDR-1:0]   ISA_FIFO_din;
  logic                  ISA_FIFO_wr_en;
  logic                  ECN;
  logic                  burst_done;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_nburst,
    output ISA_FIFO_full, ECN, burst_done,
    input  cmd_ready, ISA_FIFO_din, ISA_FIFO_wr_en
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_nburst,
    input  ISA_FIFO_full, ECN, burst_done,
    output cmd_ready, ISA_FIFO_din, ISA_FIFO_wr_en
  );

endinterface

// File: rtl/isa_credit_cnt.sv
// Outstanding-burst credit counter: saturates at MAX_OUT, ignores and flags
// a completion that arrives with nothing outstanding.
module isa_credit_cnt #(
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned OUT_BIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               dec,
  output logic [OUT_BIT-1:0] count,
  output logic               at_max,
  output logic               underflow_err
);

  logic inc_ok;
  logic dec_ok;

  assign at_max        = (count >= OUT_BIT'(MAX_OUT));
  assign underflow_err = dec & (count == '0);
  assign inc_ok        = inc & ~at_max;
  assign dec_ok        = dec & (count != '0);

  // A simultaneous issue and completion cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc_ok && !dec_ok) begin
      count <= count + OUT_BIT'(1);
    end else if (dec_ok && !inc_ok) begin
      count <= count - OUT_BIT'(1);
    end
  end

endmodule

// File: rtl/isa_issuer.sv
// Splits a host read/write command into per-burst instructions for the
// instruction FIFO, throttled by FIFO-full, ECN and an outstanding-burst credit.
module isa_issuer
  import isa_issuer_pkg::*;
#(
  parameter int unsigned ISA     = 2,
  parameter int unsigned ADDR    = 32,
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned OUT_BIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  isa_issuer_if.slave        bus,
  output logic [OUT_BIT-1:0] outstanding,
  output logic               cmd_done,
  output logic               cmd_err,
  output logic               busy
);

  state_t              state;
  logic [ISA-1:0]      op_q;
  logic [ADDR-1:0]     addr_q;
  logic [NBURST_W-1:0] remaining;

  logic            wr;
  logic            last;
  logic            cmd_ok;
  logic            at_max;
  logic            underflow_err;
  logic [ADDR-1:0] stride;

  assign busy          = (state == ISSUE);
  assign bus.cmd_ready = (state == IDLE);

  // Issue decision is a pure function of registered state and stall inputs.
  assign wr                 = busy & ~bus.ISA_FIFO_full & ~bus.ECN & ~at_max;
  assign bus.ISA_FIFO_wr_en = wr;
  assign bus.ISA_FIFO_din   = {op_q, addr_q};

  assign last     = (remaining == NBURST_W'(1));
  assign cmd_done = wr & last;

  assign cmd_ok = ((bus.cmd_op == ISA'(OP_READ)) || (bus.cmd_op == ISA'(OP_WRITE)))
                  && (bus.cmd_nburst != '0);

  assign stride = (op_q == ISA'(OP_WRITE)) ? ADDR'(STRIDE_WRITE) : ADDR'(STRIDE_READ);

  isa_credit_cnt #(
    .MAX_OUT (MAX_OUT),
    .OUT_BIT (OUT_BIT)
  ) u_credit (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc           (wr),
    .dec           (bus.burst_done),
    .count         (outstanding),
    .at_max        (at_max),
    .underflow_err (underflow_err)
  );

  // Command FSM with its datapath registers and the registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      remaining <= '0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_err <= underflow_err;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q      <= bus.cmd_op;
            addr_q    <= bus.cmd_addr;
            remaining <= bus.cmd_nburst;
            if (cmd_ok) begin
              state <= ISSUE;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Address wraps modulo 2^ADDR by construction.
          if (wr) begin
            addr_q    <= addr_q + stride;
            remaining <= remaining - NBURST_W'(1);
            if (last) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
